ecc_point_add: RTL and testbench

- Sequential affine point adder for short-Weierstrass curves y² = x³ + A·x + b over GF(P). Default curve: secp256k1.
- Accepts one point pair per `in_valid` pulse and returns R = P + Q in affine form with a one-cycle `out_valid` pulse.
- Serves as the DUT behind the team's `add.txt` point-addition pattern, and as the add/double primitive for the later scalar multiplier.
- Arithmetic uses one shared bit-serial modular multiplier and one binary extended-Euclid inverter.

---
 rtl/ecc_point_add.sv | 219 +++++++++++++++++++++
 tb/tb_ecc_point_add.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ecc_point_add.sv
// Sequential affine point adder R = P + Q on y^2 = x^3 + A*x + b over GF(P).
// One shared bit-serial modular multiplier and one binary extended-Euclid inverter.
module ecc_point_add #(
    parameter int unsigned  N = 256,
    parameter logic [N-1:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F,
    parameter logic [N-1:0] A = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] Px,
    input  logic [N-1:0] Py,
    input  logic [N-1:0] Qx,
    input  logic [N-1:0] Qy,
    output logic         out_valid,
    output logic [N-1:0] Rx,
    output logic [N-1:0] Ry,
    output logic         busy
);
    localparam int unsigned CW = $clog2(2 * N + 2);

    typedef enum logic [3:0] {
        S_IDLE, S_CLASSIFY, S_NUM, S_INV, S_LAM, S_LSQ, S_X3, S_Y3, S_DONE
    } state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt;
    logic           dbl;
    logic [N-1:0]   px, py, qx, qy, num, den, lam, tsq, x3;
    logic [N-1:0]   u, v, x1, x2, ma, mb, acc;

    logic           special_c, dbl_c, in_mul_c, mul_last_c, inv_hit_c;
    logic [N-1:0]   spec_rx_c, spec_ry_c, mul_a_c, mul_b_c, mul_next_c, inv_res_c;
    logic [N-1:0]   u_n, v_n, x1_n, x2_n, rx_d, ry_d;
    logic           out_valid_d, busy_d;

    function automatic logic [N-1:0] mod_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[N-1:0];
    endfunction

    function automatic logic [N-1:0] mod_sub(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (s[N]) s = s + {1'b0, P};
        return s[N-1:0];
    endfunction

    // x/2 mod P: an odd x gets P added first so the shift is exact
    function automatic logic [N-1:0] mod_half(input logic [N-1:0] x);
        logic [N:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, P}) : {1'b0, x};
        return s[N:1];
    endfunction

    // Special-case resolution in priority order; (0,0) is the point at infinity
    always_comb begin
        special_c = 1'b1;
        dbl_c     = 1'b0;
        spec_rx_c = '0;
        spec_ry_c = '0;
        if (px == '0 && py == '0) begin
            spec_rx_c = qx;
            spec_ry_c = qy;
        end else if (qx == '0 && qy == '0) begin
            spec_rx_c = px;
            spec_ry_c = py;
        end else if (px == qx) begin
            if (py == qy && py != '0) begin
                special_c = 1'b0;
                dbl_c     = 1'b1;
            end
        end else begin
            special_c = 1'b0;
        end
    end

    // MSB-first interleaved multiply step: acc <- 2*acc (+ b)
    always_comb begin
        mul_a_c = lam;
        mul_b_c = lam;
        case (state)
            S_NUM:   begin mul_a_c = px;  mul_b_c = px;  end
            S_LAM:   begin mul_a_c = num; mul_b_c = den; end
            S_Y3:    begin mul_a_c = lam; mul_b_c = mod_sub(px, x3); end
            default: ;
        endcase
        mul_next_c = ma[N-1] ? mod_add(mod_add(acc, acc), mb) : mod_add(acc, acc);
    end

    assign in_mul_c   = (state == S_NUM && dbl) || state == S_LAM || state == S_LSQ || state == S_Y3;
    assign mul_last_c = (cnt == CW'(N));

    // One inverter iteration; an odd-odd step subtracts and halves together
    always_comb begin
        u_n  = u;
        v_n  = v;
        x1_n = x1;
        x2_n = x2;
        if (!u[0]) begin
            u_n  = u >> 1;
            x1_n = mod_half(x1);
        end else if (!v[0]) begin
            v_n  = v >> 1;
            x2_n = mod_half(x2);
        end else if (u >= v) begin
            u_n  = (u - v) >> 1;
            x1_n = mod_half(mod_sub(x1, x2));
        end else begin
            v_n  = (v - u) >> 1;
            x2_n = mod_half(mod_sub(x2, x1));
        end
        inv_res_c = (u == N'(1)) ? x1 : x2;
    end

    assign inv_hit_c = (cnt != '0) && (u == N'(1) || v == N'(1) || cnt > CW'(2 * N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (in_valid) state_next = S_CLASSIFY;
            S_CLASSIFY: state_next = special_c ? S_DONE : S_NUM;
            S_NUM:      if (!dbl || mul_last_c) state_next = S_INV;
            S_INV:      if (inv_hit_c) state_next = S_LAM;
            S_LAM:      if (mul_last_c) state_next = S_LSQ;
            S_LSQ:      if (mul_last_c) state_next = S_X3;
            S_X3:       state_next = S_Y3;
            S_Y3:       if (mul_last_c) state_next = S_DONE;
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = (state_next == S_DONE);
        busy_d      = (state_next != S_IDLE);
        rx_d        = '0;
        ry_d        = '0;
        if (state == S_CLASSIFY && special_c) begin
            rx_d = spec_rx_c;
            ry_d = spec_ry_c;
        end else if (state == S_Y3 && mul_last_c) begin
            rx_d = x3;
            ry_d = mod_sub(mul_next_c, py);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            Rx        <= '0;
            Ry        <= '0;
        end else begin
            out_valid <= out_valid_d;
            busy      <= busy_d;
            Rx        <= rx_d;
            Ry        <= ry_d;
        end
    end

    // Datapath; cnt restarts at 0 on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0; dbl <= 1'b0;
            px  <= '0; py  <= '0; qx <= '0; qy <= '0;
            num <= '0; den <= '0; lam <= '0; tsq <= '0; x3 <= '0;
            u   <= '0; v   <= '0; x1 <= '0; x2 <= '0;
            ma  <= '0; mb  <= '0; acc <= '0;
        end else begin
            cnt <= (state_next != state || state == S_IDLE) ? '0 : cnt + CW'(1);
            if (in_mul_c) begin
                if (cnt == '0) begin
                    ma  <= mul_a_c;
                    mb  <= mul_b_c;
                    acc <= '0;
                end else begin
                    ma  <= {ma[N-2:0], 1'b0};
                    acc <= mul_next_c;
                end
            end
            case (state)
                S_IDLE: if (in_valid) begin
                    px <= Px; py <= Py; qx <= Qx; qy <= Qy;
                end
                S_CLASSIFY: dbl <= dbl_c;
                S_NUM: begin
                    if (!dbl) begin
                        num <= mod_sub(qy, py);
                        den <= mod_sub(qx, px);
                    end else if (mul_last_c) begin
                        num <= mod_add(mod_add(mod_add(mul_next_c, mul_next_c), mul_next_c), A);
                        den <= mod_add(py, py);
                    end
                end
                S_INV: begin
                    if (cnt == '0) begin
                        u <= den; v <= P; x1 <= N'(1); x2 <= '0;
                    end else if (inv_hit_c) begin
                        den <= inv_res_c;
                    end else begin
                        u <= u_n; v <= v_n; x1 <= x1_n; x2 <= x2_n;
                    end
                end
                S_LAM:   if (mul_last_c) lam <= mul_next_c;
                S_LSQ:   if (mul_last_c) tsq <= mul_next_c;
                S_X3:    x3 <= mod_sub(mod_sub(tsq, px), qx);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_point_add.sv
// Bench for ecc_point_add: secp256k1 and toy-curve (N=8, P=17, A=2) instances,
// directed known-answer steps plus random vectors against a big-integer affine model.
module tb_ecc_point_add;
    typedef logic [511:0] w_t;

    localparam logic [255:0] PK  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam logic [255:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
    localparam logic [255:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
    localparam logic [255:0] G3X = 256'hF9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9;
    localparam logic [255:0] G3Y = 256'h388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672;
    localparam int ADD_MAX  = 3 * 257 + 2 * 256 + 8;
    localparam int DBL_MAX  = 4 * 257 + 2 * 256 + 8;
    localparam int TOY_MAX  = 4 * 9 + 2 * 8 + 8;

    logic clk = 1'b0;
    logic rst_n;
    logic iv, ov, bsy;
    logic [255:0] px, py, qx, qy, rx, ry;
    logic t_iv, t_ov, t_bsy;
    logic [7:0] t_px, t_py, t_qx, t_qy, t_rx, t_ry;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ecc_point_add dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv),
        .Px(px), .Py(py), .Qx(qx), .Qy(qy),
        .out_valid(ov), .Rx(rx), .Ry(ry), .busy(bsy)
    );

    ecc_point_add #(.N(8), .P(8'd17), .A(8'd2)) dut_toy (
        .clk(clk), .rst_n(rst_n), .in_valid(t_iv),
        .Px(t_px), .Py(t_py), .Qx(t_qx), .Qy(t_qy),
        .out_valid(t_ov), .Rx(t_rx), .Ry(t_ry), .busy(t_bsy)
    );

    function automatic w_t fmul(input w_t a, input w_t b, input w_t p);
        return (a * b) % p;
    endfunction
    function automatic w_t fadd(input w_t a, input w_t b, input w_t p);
        return (a + b) % p;
    endfunction
    function automatic w_t fsub(input w_t a, input w_t b, input w_t p);
        return (a + p - b) % p;
    endfunction
    // Fermat inverse a^(p-2)
    function automatic w_t finv(input w_t a, input w_t p);
        w_t r, b, e;
        r = 512'd1; b = a; e = p - 512'd2;
        for (int i = 0; i < 512; i++) begin
            if (e[0]) r = fmul(r, b, p);
            b = fmul(b, b, p);
            e = e >> 1;
        end
        return r;
    endfunction

    task automatic ref_add(input w_t x1, input w_t y1, input w_t x2, input w_t y2,
                           input w_t p, input w_t a, output w_t ox, output w_t oy);
        w_t lam;
        if (x1 == 0 && y1 == 0) begin ox = x2; oy = y2; end
        else if (x2 == 0 && y2 == 0) begin ox = x1; oy = y1; end
        else if (x1 == x2 && (y1 != y2 || y1 == 0)) begin ox = 0; oy = 0; end
        else begin
            if (x1 == x2)
                lam = fmul(fadd(fmul(512'd3, fmul(x1, x1, p), p), a, p), finv(fmul(512'd2, y1, p), p), p);
            else
                lam = fmul(fsub(y2, y1, p), finv(fsub(x2, x1, p), p), p);
            ox = fsub(fsub(fmul(lam, lam, p), x1, p), x2, p);
            oy = fsub(fmul(lam, fsub(x1, ox, p), p), y1, p);
        end
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit toy, input logic [255:0] ax, input logic [255:0] ay,
                         input logic [255:0] bx, input logic [255:0] by, input logic v);
        if (toy) begin
            t_px = ax[7:0]; t_py = ay[7:0]; t_qx = bx[7:0]; t_qy = by[7:0]; t_iv = v;
        end else begin
            px = ax; py = ay; qx = bx; qy = by; iv = v;
        end
    endtask

    // One operation: pulse in_valid, wait (bounded) for out_valid, check result and latency
    task automatic run_op(input bit toy, input logic [255:0] ax, input logic [255:0] ay,
                          input logic [255:0] bx, input logic [255:0] by,
                          input logic [255:0] ex, input logic [255:0] ey,
                          input string tag, input int max_lat, input bit exact, input int junk_at);
        int lat;
        @(negedge clk);
        chk({tag, " ov_low_before"}, 256'(toy ? t_ov : ov), 256'd0);
        drive(toy, ax, ay, bx, by, 1'b1);
        @(negedge clk);
        t_iv = 1'b0; iv = 1'b0;
        lat = 1;
        chk({tag, " busy_after_accept"}, 256'(toy ? t_bsy : bsy), 256'd1);
        chk({tag, " rx_zero_idle"}, toy ? 256'(t_rx) : rx, 256'd0);
        while (!(toy ? t_ov : ov) && lat < 2000) begin
            if (lat == junk_at) drive(toy, 256'd123, 256'd456, 256'd789, 256'd1011, 1'b1);
            else begin t_iv = 1'b0; iv = 1'b0; end
            @(negedge clk);
            lat++;
        end
        t_iv = 1'b0; iv = 1'b0;
        chk({tag, " out_valid"}, 256'(toy ? t_ov : ov), 256'd1);
        chk({tag, " rx"}, toy ? 256'(t_rx) : rx, ex);
        chk({tag, " ry"}, toy ? 256'(t_ry) : ry, ey);
        chk({tag, " busy_at_done"}, 256'(toy ? t_bsy : bsy), 256'd1);
        if (exact) chk({tag, " latency"}, 256'(lat), 256'(max_lat));
        else       chk({tag, " latency_bound"}, 256'(lat <= max_lat), 256'd1);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r % PK;
    endfunction

    initial begin
        w_t ex, ey;
        logic [255:0] ax, ay, bx, by;
        int stray;

        rst_n = 1'b0;
        drive(1'b0, '0, '0, '0, '0, 1'b0);
        drive(1'b1, '0, '0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset out_valid", 256'(ov), 256'd0);
        chk("reset busy", 256'(bsy), 256'd0);
        chk("reset rx", rx, 256'd0);
        chk("reset ry", ry, 256'd0);
        chk("reset toy out_valid", 256'(t_ov), 256'd0);
        rst_n = 1'b1;

        // Toy curve known answers
        run_op(1'b1, 5, 1, 5, 1, 6, 3, "toy 2P", TOY_MAX, 1'b0, 0);
        run_op(1'b1, 5, 1, 6, 3, 10, 6, "toy P+2P", TOY_MAX, 1'b0, 0);
        run_op(1'b1, 3, 0, 3, 0, 0, 0, "toy y0 double", 2, 1'b1, 0);

        // secp256k1 known answers
        run_op(1'b0, GX, GY, GX, GY, G2X, G2Y, "G+G", DBL_MAX, 1'b0, 0);
        run_op(1'b0, GX, GY, G2X, G2Y, G3X, G3Y, "G+2G", ADD_MAX, 1'b0, 0);
        run_op(1'b0, GX, GY, 0, 0, GX, GY, "G+O", 2, 1'b1, 0);
        run_op(1'b0, 0, 0, G2X, G2Y, G2X, G2Y, "O+2G", 2, 1'b1, 0);
        run_op(1'b0, GX, GY, GX, PK - GY, 0, 0, "G-G", 2, 1'b1, 0);
        run_op(1'b0, GX, GY, G2X, G2Y, G3X, G3Y, "junk while busy", ADD_MAX, 1'b0, 100);

        // Reset in the middle of the inversion
        @(negedge clk);
        drive(1'b0, GX, GY, G2X, G2Y, 1'b1);
        @(negedge clk);
        iv = 1'b0;
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", 256'(ov), 256'd0);
        chk("midreset busy", 256'(bsy), 256'd0);
        chk("midreset rx", rx, 256'd0);
        chk("midreset ry", ry, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (1600) begin
            @(negedge clk);
            if (ov) stray++;
        end
        chk("no stray out_valid", 256'(stray), 256'd0);
        run_op(1'b0, GX, GY, GX, GY, G2X, G2Y, "G+G after reset", DBL_MAX, 1'b0, 0);

        // Random toy-curve vectors, back-to-back
        for (int i = 0; i < 40; i++) begin
            ax = 256'($urandom_range(0, 16)); ay = 256'($urandom_range(0, 16));
            bx = 256'($urandom_range(0, 16)); by = 256'($urandom_range(0, 16));
            if (i % 3 == 0) begin bx = ax; by = ay; end
            ref_add({256'd0, ax}, {256'd0, ay}, {256'd0, bx}, {256'd0, by}, 512'd17, 512'd2, ex, ey);
            run_op(1'b1, ax, ay, bx, by, ex[255:0], ey[255:0], $sformatf("toy rand %0d", i), TOY_MAX, 1'b0, 0);
        end

        // Random secp256k1-field vectors, back-to-back
        for (int i = 0; i < 8; i++) begin
            ax = rnd256(); ay = rnd256(); bx = rnd256(); by = rnd256();
            if (i % 4 == 0) begin bx = ax; by = ay; end
            ref_add({256'd0, ax}, {256'd0, ay}, {256'd0, bx}, {256'd0, by}, {256'd0, PK}, 512'd0, ex, ey);
            run_op(1'b0, ax, ay, bx, by, ex[255:0], ey[255:0], $sformatf("k1 rand %0d", i),
                   (i % 4 == 0) ? DBL_MAX : ADD_MAX, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
